// File: rtl/gb_debug_pkg.sv
// Shared debug-trace types: capture FSM encoding and the default
// {PC, opcode} bit positions inside a sample word.
package gb_debug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  localparam int TRACE_PC_LSB = 8;
  localparam int TRACE_OP_LSB = 0;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The array itself has no reset so it maps onto block RAM; only the read register clears.
module trace_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gb_trace_buffer.sv
// Circular capture of per-step sample words that stops a programmable
// number of samples after a masked-compare or forced trigger.
module gb_trace_buffer
  import gb_debug_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              force_trig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state,
  output logic              done,
  output logic [ADDR_W-1:0] oldest_idx,
  output logic [ADDR_W-1:0] trig_idx,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  trace_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] trig_idx_q, trig_idx_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en;
  logic              trig_hit;

  // arm takes priority over a coincident sample, which is dropped.
  assign wr_en    = sample_valid && !arm && (state_q == ARMED || state_q == POST);
  assign trig_hit = wr_en && (state_q == ARMED) &&
                    (force_trig || (((sample_data ^ trig_value) & trig_mask) == '0));

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED:   if (trig_hit) state_d = (post_count == '0) ? DONE : POST;
        POST:    if (wr_en && remaining_q == ADDR_W'(1)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    state      = state_q;
    done       = (state_q == DONE);
    oldest_idx = (count_q == FULL) ? wr_ptr_q : '0;
    trig_idx   = trig_idx_q;
    count      = count_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_idx_d  = trig_idx_q;
    remaining_d = remaining_q;
    if (arm) begin
      wr_ptr_d    = '0;
      count_d     = '0;
      trig_idx_d  = '0;
      remaining_d = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = (count_q == FULL) ? count_q : count_q + 1'b1;
      if (trig_hit) begin
        trig_idx_d  = wr_ptr_q;
        remaining_d = post_count;
      end else if (state_q == POST) begin
        remaining_d = remaining_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_idx_q  <= '0;
      remaining_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trig_idx_q  <= trig_idx_d;
      remaining_q <= remaining_d;
    end
  end

  trace_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (Clk),
    .rst_ni (reset_n),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i(sample_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_gb_trace_buffer.sv
// Scoreboard bench for gb_trace_buffer at DEPTH=8: stimulus pushes expectations
// derived from a history-based capture model, a negedge monitor pops and compares.
module tb_gb_trace_buffer;

  localparam int DW = 24;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          Clk = 1'b0;
  logic          reset_n;
  logic          arm, force_trig, sample_valid;
  logic [DW-1:0] sample_data, trig_value, trig_mask;
  logic [AW-1:0] post_count, rd_addr;
  logic [DW-1:0] rd_data;
  logic [1:0]    state;
  logic          done;
  logic [AW-1:0] oldest_idx, trig_idx;
  logic [AW:0]   count;

  gb_trace_buffer #(.DATA_W(DW), .DEPTH(DP)) dut (
    .Clk(Clk), .reset_n(reset_n), .arm(arm), .force_trig(force_trig),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .state(state), .done(done),
    .oldest_idx(oldest_idx), .trig_idx(trig_idx), .count(count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  // Reference model: mode 0..3 = IDLE/ARMED/POST/DONE, hist = samples since arm.
  int          m_mode = 0;
  int          m_trig = 0;
  int          m_rem = 0;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_ram[DP];
  bit          m_ok[DP];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, expv);
    end
  endtask

  function automatic logic [31:0] actual(input int k);
    case (k)
      0:       return 32'(state);
      1:       return 32'(done);
      2:       return 32'(count);
      3:       return 32'(trig_idx);
      4:       return 32'(oldest_idx);
      default: return 32'(rd_data);
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "state";
      1:       return "done";
      2:       return "count";
      3:       return "trig_idx";
      4:       return "oldest_idx";
      default: return "rd_data";
    endcase
  endfunction

  exp_t mon_e;
  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      check(kname(mon_e.kind), actual(mon_e.kind), mon_e.val);
    end
  end

  function automatic int m_count();
    return (hist.size() >= DP) ? DP : hist.size();
  endfunction

  function automatic int m_oldest();
    return (hist.size() >= DP) ? (hist.size() % DP) : 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_mode = 0;
    m_trig = 0;
    m_rem  = 0;
  endtask

  // One clock of stimulus: drive, predict, push expectations, advance to next posedge+1.
  task automatic step(input logic a, input logic v, input logic f, input logic [DW-1:0] d,
                      input logic [AW-1:0] pc, input logic re, input logic [AW-1:0] ra);
    int pos;
    arm = a; sample_valid = v; force_trig = f; sample_data = d;
    post_count = pc; rd_addr = ra;
    if (re && m_ok[ra]) exp_q.push_back('{cyc + 1, 5, 32'(m_ram[ra])});
    if (a) begin
      hist.delete();
      m_mode = 1; m_trig = 0; m_rem = 0;
    end else if (v && (m_mode == 1 || m_mode == 2)) begin
      pos = hist.size();
      hist.push_back(d);
      m_ram[pos % DP] = d;
      m_ok[pos % DP]  = 1'b1;
      if (m_mode == 1) begin
        if (f || (((d ^ trig_value) & trig_mask) == '0)) begin
          m_trig = pos % DP;
          if (pc == 0) m_mode = 3;
          else begin m_mode = 2; m_rem = int'(pc); end
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_mode = 3;
      end
    end
    exp_q.push_back('{cyc + 1, 0, 32'(m_mode)});
    exp_q.push_back('{cyc + 1, 1, 32'(m_mode == 3)});
    exp_q.push_back('{cyc + 1, 2, 32'(m_count())});
    exp_q.push_back('{cyc + 1, 3, 32'(m_trig)});
    exp_q.push_back('{cyc + 1, 4, 32'(m_oldest())});
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".state"}, 32'(state), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".oldest"}, 32'(oldest_idx), 32'd0);
    check({tag, ".trig"}, 32'(trig_idx), 32'd0);
    check({tag, ".rd_data"}, 32'(rd_data), 32'd0);
  endtask

  task automatic read_back();
    int n, o;
    n = m_count();
    o = m_oldest();
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, '0, 1, AW'((o + k) % DP));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          a, v, f, re;
    logic [DW-1:0] d;
    reset_n = 1'b0; arm = 0; force_trig = 0; sample_valid = 0; sample_data = '0;
    trig_value = '0; trig_mask = '0; post_count = '0; rd_addr = '0;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // No arm: samples must be ignored.
    for (int i = 0; i < 10; i++) step(0, 1, 0, DW'(i + 1), '0, 0, '0);

    // Value compare, post_count=1; sample 5 arrives after DONE.
    trig_mask = 24'hFFFFFF; trig_value = 24'h000003;
    step(1, 0, 0, '0, 3'd1, 0, '0);
    for (int i = 1; i <= 5; i++) step(0, 1, 0, DW'(i), 3'd1, 0, '0);
    step(0, 0, 0, '0, '0, 1, 3'd3);
    read_back();

    // Wrap, then forced trigger with post_count=0.
    trig_value = 24'hFFFFFF;
    step(1, 0, 0, '0, '0, 0, '0);
    for (int i = 1; i <= 12; i++) step(0, 1, 0, DW'(i), '0, 0, '0);
    step(0, 1, 1, DW'(13), '0, 0, '0);
    read_back();

    // arm coincident with a sample: sample dropped, next lands at index 0.
    trig_value = 24'h000000;
    step(1, 1, 0, 24'h000055, '0, 0, '0);
    step(0, 1, 0, 24'h000066, '0, 0, '0);
    step(0, 0, 0, '0, '0, 1, 3'd0);

    // Masked compare on the middle byte.
    trig_mask = 24'h00FF00; trig_value = 24'h00AB00;
    step(1, 0, 0, '0, '0, 0, '0);
    step(0, 1, 0, 24'h12AC34, '0, 0, '0);
    step(0, 1, 0, 24'h12AB34, '0, 0, '0);
    read_back();

    // Asynchronous reset while in POST with remaining=3.
    trig_mask = 24'hFFFFFF; trig_value = 24'h000077;
    step(1, 0, 0, '0, '0, 0, '0);
    step(0, 1, 0, 24'h000077, 3'd3, 0, '0);
    @(negedge Clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 24'h000077, 3'd2, 0, '0);

    // Randomized captures.
    for (int r = 0; r < 24; r++) begin
      trig_value = DW'($urandom);
      trig_mask  = (r % 5 == 0) ? '0 : DW'($urandom & $urandom);
      step(1, 0, 0, '0, '0, 0, '0);
      for (int c = 0; c < 40; c++) begin
        a  = ($urandom_range(0, 49) == 0);
        v  = ($urandom_range(0, 9) < 7);
        f  = ($urandom_range(0, 29) == 0);
        re = ($urandom_range(0, 3) == 0);
        d  = ($urandom_range(0, 3) == 0) ? (trig_value ^ (DW'($urandom) & ~trig_mask))
                                         : DW'($urandom);
        step(a, v, f, d, AW'($urandom_range(0, DP - 1)), re, AW'($urandom_range(0, DP - 1)));
        if (m_mode == 3) break;
      end
      read_back();
    end

    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
